// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, control-word layout and defaults shared by the 8-bit bus CPU control path.
package cpu_pkg;
    localparam int STEPS_DEFAULT = 5;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CW_HLT  = 15;
    localparam int CW_MI   = 14;
    localparam int CW_RI   = 13;
    localparam int CW_RO   = 12;
    localparam int CW_IO   = 11;
    localparam int CW_II   = 10;
    localparam int CW_AI   = 9;
    localparam int CW_AO   = 8;
    localparam int CW_BI   = 7;
    localparam int CW_SUMO = 6;
    localparam int CW_SU   = 5;
    localparam int CW_OI   = 4;
    localparam int CW_CE   = 3;
    localparam int CW_CO   = 2;
    localparam int CW_J    = 1;
    localparam int CW_FI   = 0;

    // Field order matches the CW_* bit indices above.
    typedef struct packed {
        logic hlt;
        logic mi;
        logic ri;
        logic ro;
        logic io;
        logic ii;
        logic ai;
        logic ao;
        logic bi;
        logic sumo;
        logic su;
        logic oi;
        logic ce;
        logic co;
        logic j;
        logic fi;
    } ctrl_t;
endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: combinational decode of (opcode, T-state, flags) into the control word.
module microcode_rom
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [2:0] step,
    input  logic       carry,
    input  logic       zero,
    output ctrl_t      cw
);
    logic s2, s3, s4;
    assign s2 = step == 3'd2;
    assign s3 = step == 3'd3;
    assign s4 = step == 3'd4;
    always_comb begin
        cw = '0;
        if (step == 3'd0) begin
            cw.co = 1'b1;
            cw.mi = 1'b1;
        end else if (step == 3'd1) begin
            cw.ro = 1'b1;
            cw.ii = 1'b1;
            cw.ce = 1'b1;
        end else begin
            case (opcode)
                OP_LDA: begin
                    cw.io = s2;
                    cw.mi = s2;
                    cw.ro = s3;
                    cw.ai = s3;
                end
                OP_ADD, OP_SUB: begin
                    cw.io   = s2;
                    cw.mi   = s2;
                    cw.ro   = s3;
                    cw.bi   = s3;
                    cw.sumo = s4;
                    cw.ai   = s4;
                    cw.fi   = s4;
                    cw.su   = s4 && opcode == OP_SUB;
                end
                OP_STA: begin
                    cw.io = s2;
                    cw.mi = s2;
                    cw.ao = s3;
                    cw.ri = s3;
                end
                OP_LDI: begin
                    cw.io = s2;
                    cw.ai = s2;
                end
                OP_JMP: begin
                    cw.io = s2;
                    cw.j  = s2;
                end
                // Conditional jumps only look at the flags during T2.
                OP_JC: begin
                    cw.io = s2 && carry;
                    cw.j  = s2 && carry;
                end
                OP_JZ: begin
                    cw.io = s2 && zero;
                    cw.j  = s2 && zero;
                end
                OP_OUT: begin
                    cw.ao = s2;
                    cw.oi = s2;
                end
                OP_HLT: cw.hlt = s2;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: instruction register, T-state counter and halt latch driving the CPU control strobes.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int STEPS = STEPS_DEFAULT
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       hlt,
    output logic       mi,
    output logic       ri,
    output logic       ro,
    output logic       io,
    output logic       ii,
    output logic       ai,
    output logic       ao,
    output logic       bi,
    output logic       sumo,
    output logic       su,
    output logic       oi,
    output logic       ce,
    output logic       co,
    output logic       j,
    output logic       fi,
    output logic [2:0] step
);
    localparam logic [2:0] LAST = 3'(STEPS - 1);
    logic [7:0] ir;
    logic [2:0] step_q;
    logic       halted;
    ctrl_t      rom_cw, cw;
    microcode_rom u_rom (
        .opcode(ir[7:4]),
        .step  (step_q),
        .carry (carry_flag),
        .zero  (zero_flag),
        .cw    (rom_cw)
    );
    // Reset gating is combinational so strobes drop the moment clear_n falls.
    always_comb begin
        cw = rom_cw;
        if (halted) begin
            cw = '0;
            cw.hlt = 1'b1;
        end
        if (!clear_n) cw = '0;
    end
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            ir     <= '0;
            step_q <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (cw.ii) ir <= bus_in;
            if (cw.hlt) halted <= 1'b1;
            else step_q <= step_q == LAST ? 3'd0 : step_q + 3'd1;
        end
    end
    assign {hlt, mi, ri, ro, io, ii, ai, ao, bi, sumo, su, oi, ce, co, j, fi} = cw;
    assign bus_out = cw.io ? {4'b0000, ir[3:0]} : 8'bz;
    assign step    = step_q;
endmodule
